// File: rtl/mips_store_pkg.sv
// Shared types for the MIPS store drain: field widths, FSM states
// and the FIFO entry layout.
package mips_store_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_FLUSHED = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/mips_store_drain_if.sv
// Valid/ready store stream from the drain buffer to its consumer.
interface mips_store_drain_if;
    import mips_store_pkg::*;

    logic              M_VALID;
    logic              M_READY;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_DATA;

    modport master (
        output M_VALID,
        output M_ADDR,
        output M_DATA,
        input  M_READY
    );

    modport slave (
        input  M_VALID,
        input  M_ADDR,
        input  M_DATA,
        output M_READY
    );

endinterface

// File: rtl/mips_store_fifo.sv
// Store FIFO with extended pointers; the extra MSB tells full from
// empty so wrap-around needs no special handling.
module mips_store_fifo
    import mips_store_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_entry,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Head reads as zero when empty so reset leaves the bus quiet.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mips_store_drain.sv
// Buffers the core's store pulses into a back-pressurable stream and
// reports FLUSHED once DONE is seen and every store has left.
module mips_store_drain
    import mips_store_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                CK,
    input  logic                RESETN,
    input  logic                IN_VALID,
    input  logic [ADDR_W-1:0]   IN_ADDR,
    input  logic [DATA_W-1:0]   IN_DATA,
    input  logic                IN_DONE,
    mips_store_drain_if.master  m,
    output logic [15:0]         STORE_COUNT,
    output logic [DATA_W-1:0]   CHECKSUM,
    output logic                OVERFLOW,
    output logic                FLUSHED
);

    state_t state;
    state_t state_nx;
    logic   full;
    logic   empty;
    logic   pop;
    logic   push;
    logic   drop;
    logic   live;
    entry_t head;
    entry_t wr_entry;

    assign live     = (state != ST_FLUSHED);
    assign pop      = !empty && m.M_READY;
    assign push     = IN_VALID && live && (!full || pop);
    assign drop     = IN_VALID && live && full && !pop;
    assign wr_entry = '{addr: IN_ADDR, data: IN_DATA};

    mips_store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CK),
        .rst_n    (RESETN),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign m.M_VALID = !empty;
    assign m.M_ADDR  = head.addr;
    assign m.M_DATA  = head.data;
    assign FLUSHED   = (state == ST_FLUSHED);

    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) state <= ST_RUN;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == ST_RUN):   if (IN_DONE) state_nx = ST_DRAIN;
            (state == ST_DRAIN): if (empty && !push) state_nx = ST_FLUSHED;
            default:             state_nx = state;
        endcase
    end

    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            STORE_COUNT <= '0;
            CHECKSUM    <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            if (push) begin
                if (STORE_COUNT != 16'hFFFF) STORE_COUNT <= STORE_COUNT + 16'd1;
                CHECKSUM <= CHECKSUM + IN_DATA;
            end
            if (drop) OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_store_drain.sv
// Directed self-checking bench for mips_store_drain.
module tb_mips_store_drain;
    import mips_store_pkg::*;

    logic              CK = 1'b0;
    logic              RESETN = 1'b0;
    logic              IN_VALID = 1'b0;
    logic [ADDR_W-1:0] IN_ADDR = '0;
    logic [DATA_W-1:0] IN_DATA = '0;
    logic              IN_DONE = 1'b0;
    logic [15:0]       STORE_COUNT;
    logic [DATA_W-1:0] CHECKSUM;
    logic              OVERFLOW;
    logic              FLUSHED;

    int checks = 0;
    int errors = 0;

    mips_store_drain_if mif ();

    mips_store_drain #(.DEPTH(8)) dut (
        .CK          (CK),
        .RESETN      (RESETN),
        .IN_VALID    (IN_VALID),
        .IN_ADDR     (IN_ADDR),
        .IN_DATA     (IN_DATA),
        .IN_DONE     (IN_DONE),
        .m           (mif),
        .STORE_COUNT (STORE_COUNT),
        .CHECKSUM    (CHECKSUM),
        .OVERFLOW    (OVERFLOW),
        .FLUSHED     (FLUSHED)
    );

    always #5 CK = ~CK;

    task automatic step;
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset;
        RESETN      = 1'b0;
        IN_VALID    = 1'b0;
        IN_ADDR     = '0;
        IN_DATA     = '0;
        IN_DONE     = 1'b0;
        mif.M_READY = 1'b0;
        step();
        step();
        RESETN = 1'b1;
        step();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (mif.M_VALID !== 1'b0 || mif.M_ADDR !== 5'd0 || mif.M_DATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus got v=%b a=%h d=%h exp 0", mif.M_VALID, mif.M_ADDR, mif.M_DATA);
        end
        checks++;
        if (STORE_COUNT !== 16'd0 || CHECKSUM !== 32'd0 || OVERFLOW !== 1'b0 || FLUSHED !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got c=%h s=%h o=%b f=%b exp 0", STORE_COUNT, CHECKSUM, OVERFLOW, FLUSHED);
        end
        for (int i = 1; i <= 3; i++) begin
            IN_VALID = 1'b1;
            IN_ADDR  = 5'(i);
            IN_DATA  = 32'(i * 16);
            step();
        end
        IN_VALID = 1'b0;
        checks++;
        if (mif.M_VALID !== 1'b1 || STORE_COUNT !== 16'd3) begin
            errors++;
            $display("FAIL pre_reset_fill got v=%b c=%0d exp v=1 c=3", mif.M_VALID, STORE_COUNT);
        end
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if (mif.M_VALID !== 1'b0 || mif.M_ADDR !== 5'd0 || mif.M_DATA !== 32'd0 ||
            STORE_COUNT !== 16'd0 || CHECKSUM !== 32'd0 || OVERFLOW !== 1'b0 || FLUSHED !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b a=%h d=%h c=%h s=%h o=%b f=%b exp all 0",
                     mif.M_VALID, mif.M_ADDR, mif.M_DATA, STORE_COUNT, CHECKSUM, OVERFLOW, FLUSHED);
        end
        step();
        RESETN = 1'b1;
        step();
        checks++;
        if (mif.M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty got v=%b exp 0", mif.M_VALID);
        end
    endtask

    task automatic test_single;
        do_reset();
        mif.M_READY = 1'b1;
        IN_VALID = 1'b1;
        IN_ADDR  = 5'd3;
        IN_DATA  = 32'hA5;
        step();
        IN_VALID = 1'b0;
        checks++;
        if (mif.M_VALID !== 1'b1 || mif.M_ADDR !== 5'd3 || mif.M_DATA !== 32'hA5) begin
            errors++;
            $display("FAIL single_head got v=%b a=%h d=%h exp 1 03 a5", mif.M_VALID, mif.M_ADDR, mif.M_DATA);
        end
        checks++;
        if (STORE_COUNT !== 16'd1 || CHECKSUM !== 32'hA5) begin
            errors++;
            $display("FAIL single_count got c=%0d s=%h exp 1 a5", STORE_COUNT, CHECKSUM);
        end
        step();
        checks++;
        if (mif.M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_popped got v=%b exp 0", mif.M_VALID);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            IN_VALID = 1'b1;
            IN_ADDR  = 5'(i);
            IN_DATA  = 32'(i);
            step();
        end
        IN_VALID = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b1 || STORE_COUNT !== 16'd8 || CHECKSUM !== 32'd36) begin
            errors++;
            $display("FAIL overflow_status got o=%b c=%0d s=%0d exp 1 8 36", OVERFLOW, STORE_COUNT, CHECKSUM);
        end
        mif.M_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (mif.M_VALID !== 1'b1 || mif.M_DATA !== 32'(i)) begin
                errors++;
                $display("FAIL overflow_drain_%0d got v=%b d=%0d exp 1 %0d", i, mif.M_VALID, mif.M_DATA, i);
            end
            step();
        end
        checks++;
        if (mif.M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty got v=%b exp 0", mif.M_VALID);
        end
    endtask

    task automatic test_full_pop;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 32'(i);
            step();
        end
        mif.M_READY = 1'b1;
        IN_DATA     = 32'h55;
        step();
        IN_VALID = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b0 || STORE_COUNT !== 16'd9) begin
            errors++;
            $display("FAIL full_pop_status got o=%b c=%0d exp 0 9", OVERFLOW, STORE_COUNT);
        end
        for (int i = 2; i <= 9; i++) begin
            exp_d = (i == 9) ? 32'h55 : 32'(i);
            checks++;
            if (mif.M_VALID !== 1'b1 || mif.M_DATA !== exp_d) begin
                errors++;
                $display("FAIL full_pop_drain_%0d got v=%b d=%h exp 1 %h", i, mif.M_VALID, mif.M_DATA, exp_d);
            end
            step();
        end
        checks++;
        if (mif.M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_empty got v=%b exp 0", mif.M_VALID);
        end
    endtask

    task automatic test_flush;
        logic [4:0] rdy;
        rdy = 5'b10101;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 32'(i * 10);
            step();
        end
        IN_VALID = 1'b0;
        IN_DONE  = 1'b1;
        step();
        IN_DONE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mif.M_READY = rdy[4-k];
            checks++;
            if (FLUSHED !== 1'b0) begin
                errors++;
                $display("FAIL flush_early_%0d got f=%b exp 0", k, FLUSHED);
            end
            step();
        end
        mif.M_READY = 1'b0;
        checks++;
        if (FLUSHED !== 1'b0 || mif.M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL flush_at_pop3 got f=%b v=%b exp 0 0", FLUSHED, mif.M_VALID);
        end
        step();
        checks++;
        if (FLUSHED !== 1'b1) begin
            errors++;
            $display("FAIL flush_rise got f=%b exp 1", FLUSHED);
        end
        IN_VALID = 1'b1;
        IN_DATA  = 32'hDEAD;
        step();
        step();
        IN_VALID = 1'b0;
        checks++;
        if (STORE_COUNT !== 16'd3 || CHECKSUM !== 32'd60 || mif.M_VALID !== 1'b0 ||
            OVERFLOW !== 1'b0 || FLUSHED !== 1'b1) begin
            errors++;
            $display("FAIL flush_ignore got c=%0d s=%0d v=%b o=%b f=%b exp 3 60 0 0 1",
                     STORE_COUNT, CHECKSUM, mif.M_VALID, OVERFLOW, FLUSHED);
        end
    endtask

    task automatic test_done_empty;
        do_reset();
        IN_DONE = 1'b1;
        step();
        checks++;
        if (FLUSHED !== 1'b0) begin
            errors++;
            $display("FAIL done_empty_n got f=%b exp 0", FLUSHED);
        end
        step();
        IN_DONE = 1'b0;
        checks++;
        if (FLUSHED !== 1'b1) begin
            errors++;
            $display("FAIL done_empty_n1 got f=%b exp 1", FLUSHED);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] sum;
        logic [31:0] d;
        sum = '0;
        do_reset();
        mif.M_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d        = 32'h0101_0101 * 32'(i) + 32'hF000_0007;
            sum      = sum + d;
            IN_VALID = 1'b1;
            IN_ADDR  = 5'(i + 7);
            IN_DATA  = d;
            step();
            checks++;
            if (mif.M_VALID !== 1'b1 || mif.M_DATA !== d || mif.M_ADDR !== 5'(i + 7)) begin
                errors++;
                $display("FAIL wrap_out_%0d got v=%b a=%h d=%h exp 1 %h %h",
                         i, mif.M_VALID, mif.M_ADDR, mif.M_DATA, 5'(i + 7), d);
            end
        end
        IN_VALID = 1'b0;
        step();
        checks++;
        if (mif.M_VALID !== 1'b0 || OVERFLOW !== 1'b0 || STORE_COUNT !== 16'd20 || CHECKSUM !== sum) begin
            errors++;
            $display("FAIL wrap_status got v=%b o=%b c=%0d s=%h exp 0 0 20 %h",
                     mif.M_VALID, OVERFLOW, STORE_COUNT, CHECKSUM, sum);
        end
    endtask

    initial begin
        mif.M_READY = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_flush();
        test_done_empty();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_store_drain.md
# mips_store_drain

Downstream companion to the single-cycle MIPS core. It captures every store the core reports on its output port (address/data/valid) into a small FIFO. It forwards each store to a consumer over a valid/ready stream. It keeps a store count and a data checksum, and after the core raises DONE it signals FLUSHED once every buffered store has been delivered. The testbench and any external result sink see a back-pressurable, lossless-or-flagged store stream instead of a one-cycle pulse.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- CK  in  1  clock, all state on rising edge
- RESETN  in  1  asynchronous reset, active low
- IN_VALID  in  1  core's OUTVALID; a store is present this cycle
- IN_ADDR  in  5  core's OUTADDR (word address)
- IN_DATA  in  32  core's OUTDATA
- IN_DONE  in  1  core's DONE (syscall reached)
- M_VALID  out  1  head entry available
- M_READY  in  1  consumer accepts head this cycle
- M_ADDR  out  5  head entry address
- M_DATA  out  32  head entry data
- STORE_COUNT  out  16  stores accepted, saturating
- CHECKSUM  out  32  sum mod 2^32 of accepted IN_DATA
- OVERFLOW  out  1  sticky; a store was dropped
- FLUSHED  out  1  sticky; DONE seen and FIFO drained

## Operation
- States: RUN (reset state), DRAIN, FLUSHED.
- RUN → DRAIN when IN_DONE=1 is sampled.
- DRAIN → FLUSHED when the FIFO is empty after this edge, i.e. occupancy 0 and no accepted push this cycle.
- FLUSHED is terminal until reset.
- Push condition: IN_VALID=1, state is RUN or DRAIN, and the FIFO is not full or a pop occurs the same cycle.
  - On push: write {IN_ADDR, IN_DATA]; STORE_COUNT += 1, saturating at 16'hFFFF; CHECKSUM += IN_DATA, 32-bit wrap.
- IN_VALID=1 in RUN/DRAIN with the FIFO full and no pop: drop the store, set OVERFLOW. Count and checksum are unchanged.
- In FLUSHED, IN_VALID is ignored: no push, no count, no overflow.
- Pop: M_VALID=1 and M_READY=1 at the edge. The head pointer advances.
- M_VALID = FIFO not empty. M_ADDR/M_DATA are the head entry and stay stable while M_VALID=1 and M_READY=0.
- M_READY while M_VALID=0 has no effect.
- Pointers are log2(DEPTH)+1 bits. Full/empty come from the MSB compare, so wrap-around needs no special case.
- FLUSHED=1 exactly when the state is FLUSHED.

## Timing
- Reset (RESETN low, asynchronous):
  - State = RUN; FIFO empty.
  - M_VALID=0, M_ADDR=0, M_DATA=0.
  - STORE_COUNT=0, CHECKSUM=0, OVERFLOW=0, FLUSHED=0.
- Reset deassertion is synchronous to CK by the integrator.
- Reset mid-operation discards all buffered entries immediately.
- Push-to-M_VALID latency: 1 cycle. A store sampled at edge N shows at the head after edge N, when the FIFO was empty.
- No combinational path from IN_* to M_*.
- Throughput: one push and one pop per cycle. Simultaneous push and pop leaves occupancy unchanged.
- STORE_COUNT, CHECKSUM and OVERFLOW update at the same edge as the push or drop.
- DONE with an already-empty FIFO: DRAIN at edge N, FLUSHED at edge N+1.
- DONE and IN_VALID in the same cycle: the store is accepted and must drain before FLUSHED.
- IN_DONE held high or toggled after RUN has no further effect.

## Structure
- Package `mips_store_pkg`:
  - ADDR_W=5, DATA_W=32
  - state enum {RUN, DRAIN, FLUSHED}
  - packed entry struct {addr, data}
- Sub-module `mips_store_fifo`: parameterised DEPTH, synchronous push/pop, full/empty/head outputs, async active-low reset.
- Top `mips_store_drain` holds the FSM, counters, checksum and overflow logic.

## Test plan
- Reset: assert RESETN=0 mid-stream with 3 entries queued → all outputs are 0 immediately. FIFO is empty after release (M_VALID=0).
- Single store, with M_READY=1:
  - Stimulus: IN_VALID=1, IN_ADDR=3, IN_DATA=32'hA5 for one cycle.
  - Next cycle: M_VALID=1, M_ADDR=3, M_DATA=32'hA5.
  - STORE_COUNT=1, CHECKSUM=32'hA5.
- Overflow, with M_READY=0 and DEPTH=8:
  - Stimulus: 9 back-to-back stores of data 1..9.
  - 8 entries held, OVERFLOW=1, STORE_COUNT=8, CHECKSUM=36.
  - Draining yields data 1..8 in order.
- Full with simultaneous pop: FIFO full, M_READY=1, IN_VALID=1 with data 32'h55 → store accepted, OVERFLOW stays 0, occupancy stays 8, 32'h55 emerges last.
- Drain then flush:
  - 3 entries queued, IN_DONE pulse, M_READY toggling 1,0,1,0,1.
  - FLUSHED rises exactly one edge after the third pop.
  - IN_VALID afterwards leaves STORE_COUNT unchanged.
- Wrap-around: 20 stores with M_READY=1 throughout → 20 in-order outputs, no overflow, CHECKSUM equals the software sum.
